ps2_game_cmd: RTL
=================

Name: ps2_game_cmd

Overview:
Parametrised successor to the game keyboard controller. It consumes the byte stream from the PS/2 reader as code plus valid strobe, and tracks make/break/extended prefixes with a small FSM. It keeps a held bit per game key and generates single-cycle press pulses with typematic-repeat suppression. It drives the game-control outputs (jump, pause, help, saturating velocity) fully synchronously on one clock. It sits between the PS/2 reader and the bird/pipe game logic.

Parameters:
VEL_W, 2, width of velocity output
VEL_MIN, 1, lowest velocity value
VEL_MAX, 3, highest velocity value
VEL_INIT, 2, velocity after reset
TIMEOUT, 2500000, idle cycles in a prefix state before the FSM abandons the sequence (100 ms at 25 MHz)
KEY_JUMP, 8'h29, scan code for jump (Space)
KEY_UP, 8'h1C, scan code for speed up (A)
KEY_DN, 8'h23, scan code for speed down (D)
KEY_PAUSE, 8'h4D, scan code for pause (P)
KEY_HELP, 8'h33, scan code for help (H)

Ports:
clk  in  1  system clock (25 MHz)
reset  in  1  synchronous, active-high reset
code  in  8  scan-code byte from the PS/2 reader
code_valid  in  1  one-cycle strobe: code holds a new byte
btn  in  1  asynchronous push-button jump input
jump  out  1  level: jump key held or btn asserted
pause  out  1  pause toggle state
help  out  1  help toggle state
velocity  out  VEL_W  current scroll velocity
held  out  5  held bits {help,pause,dn,up,jump}
press  out  5  one-cycle press pulses, same bit order
frame_err  out  1  one-cycle pulse on prefix timeout or illegal prefix sequence

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: state=IDLE, held=0, press=0, pause=0, help=0, velocity=VEL_INIT, frame_err=0, timeout counter=0, btn synchroniser=0. A reset mid-sequence discards any partial prefix.
- btn passes through a 2-flop synchroniser. jump = held[0] | btn_s (registered, so 1 cycle after held or btn_s).
- Prefix FSM advances only on code_valid:
  - IDLE: F0->BRK; E0->EXT; any other byte = make(code)->IDLE.
  - BRK: byte = break(code)->IDLE. F0 or E0 here -> frame_err, IDLE.
  - EXT: F0->EXT_BRK; other byte = extended make, ignored ->IDLE.
  - EXT_BRK: any byte = extended break, ignored ->IDLE.
- Extended codes never match game keys. E0 29 does not alter held[0].
- Timeout: in BRK/EXT/EXT_BRK, a counter increments each cycle without code_valid. It clears on code_valid and in IDLE. On reaching TIMEOUT-1: frame_err pulse, state->IDLE.
- Make of key k (code_valid at cycle N): held[k]=1 at N+1. press[k]=1 at N+1 for one cycle only if held[k] was 0 (auto-repeat makes produce no pulse).
- Break of key k: held[k]=0 at N+1, no pulse. Break of a key not held has no effect.
- Non-game bytes update nothing.
- pause toggles on press[3]; help toggles on press[4]. Both are registered from press, so they change at N+2.
- velocity, at N+2:
  - press[1] increments, saturating at VEL_MAX.
  - press[2] decrements, saturating at VEL_MIN.
  - Both up and down pulses in the same cycle cannot occur (one byte per cycle). Any such occurrence is defined as no change.
  - While pause=1, velocity changes are ignored.
- All arithmetic is on VEL_W bits. VEL_MIN <= VEL_INIT <= VEL_MAX <= 2^VEL_W-1 is required; an elaboration check fails otherwise.
- No latch or derived-clock logic. Every flop uses clk.

Decomposition:
- Package ps2_codes_pkg holds:
  - prefix constants BREAK=8'hF0, EXT=8'hE0
  - FSM state encoding (IDLE, BRK, EXT, EXT_BRK, 2 bits)
  - key index constants K_JUMP=0, K_UP=1, K_DN=2, K_PAUSE=3, K_HELP=4
- One sub-module, ps2_prefix_fsm: code/code_valid/timeout in; make_valid, break_valid, key_code, frame_err out.
- Key matching, held/press logic, toggles and velocity stay in the top.

Test Plan:
- Reset, then idle 10 cycles -> velocity=2, pause=0, help=0, held=0, press=0, jump=0.
- Bytes 29, 29, 29, F0 29 (with gaps) -> press[0] exactly once. jump=1 from the first 29 plus 1 cycle until 1 cycle after the break byte, then jump=0.
- Velocity saturation: 1C F0 1C x3 -> velocity 3 and stays 3. Then 23 F0 23 x3 -> velocity 1 and stays 1.
- Pause: 4D F0 4D -> pause=1 at N+2. Then 1C F0 1C -> velocity unchanged. Then 4D F0 4D -> pause=0.
- Extended/timeout:
  - E0 29 -> held[0] stays 0.
  - F0 followed by 2500000 idle cycles -> frame_err pulse, state IDLE. The next 33 toggles help to 1.
- btn asserted async mid-cycle -> jump=1 within 3 cycles. Also hold 1C then assert reset mid F0 sequence -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 scan-code prefixes, prefix-FSM state encoding and game-key indices.
// Pure declarations; no logic, no latency.
package ps2_codes_pkg;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } prefix_state_t;

    localparam int K_JUMP  = 0;
    localparam int K_UP    = 1;
    localparam int K_DN    = 2;
    localparam int K_PAUSE = 3;
    localparam int K_HELP  = 4;
    localparam int N_KEYS  = 5;

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Tracks F0/E0 prefixes; make/break strobes are decoded in the same cycle as code_valid.
// frame_err is registered (visible one cycle after the offending byte or timeout); no backpressure.
module ps2_prefix_fsm
    import ps2_codes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_code,
    input  logic       i_code_valid,
    input  logic       i_timeout,
    output logic       o_make_valid,
    output logic       o_break_valid,
    output logic [7:0] o_key_code,
    output logic       o_frame_err,
    output logic       o_busy
);

    prefix_state_t r_state;
    logic          r_frame_err;
    logic          w_is_prefix;

    assign w_is_prefix   = (i_code == BREAK) || (i_code == EXT);
    assign o_make_valid  = i_code_valid && (r_state == S_IDLE) && !w_is_prefix;
    assign o_break_valid = i_code_valid && (r_state == S_BRK)  && !w_is_prefix;
    assign o_key_code    = i_code;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (i_code_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_code == BREAK)    r_state <= S_BRK;
                        else if (i_code == EXT) r_state <= S_EXT;
                    end
                    S_BRK: begin
                        // A second prefix inside a break sequence is malformed.
                        if (w_is_prefix) r_frame_err <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    S_EXT: begin
                        r_state <= (i_code == BREAK) ? S_EXT_BRK : S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (i_timeout && r_state != S_IDLE) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_game_cmd.sv
// Scan-code stream to game controls: held/press at N+1, jump/pause/help/velocity at N+2.
// Accepts one byte per cycle, no backpressure.
module ps2_game_cmd
    import ps2_codes_pkg::*;
#(
    parameter int         VEL_W     = 2,
    parameter int         VEL_MIN   = 1,
    parameter int         VEL_MAX   = 3,
    parameter int         VEL_INIT  = 2,
    parameter int         TIMEOUT   = 2500000,
    parameter logic [7:0] KEY_JUMP  = 8'h29,
    parameter logic [7:0] KEY_UP    = 8'h1C,
    parameter logic [7:0] KEY_DN    = 8'h23,
    parameter logic [7:0] KEY_PAUSE = 8'h4D,
    parameter logic [7:0] KEY_HELP  = 8'h33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       code,
    input  logic             code_valid,
    input  logic             btn,
    output logic             jump,
    output logic             pause,
    output logic             help,
    output logic [VEL_W-1:0] velocity,
    output logic [4:0]       held,
    output logic [4:0]       press,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    if (!(VEL_MIN <= VEL_INIT && VEL_INIT <= VEL_MAX && VEL_MAX <= (2 ** VEL_W) - 1)) begin : g_bad_vel
        $error("ps2_game_cmd: need VEL_MIN <= VEL_INIT <= VEL_MAX <= 2^VEL_W-1");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("ps2_game_cmd: TIMEOUT must be at least 2");
    end

    logic             w_make_valid;
    logic             w_break_valid;
    logic [7:0]       w_key_code;
    logic             w_busy;
    logic             w_timeout;
    logic [4:0]       w_hit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_s1;
    logic             r_btn_s2;
    logic [4:0]       r_held;
    logic [4:0]       r_press;
    logic             r_jump;
    logic             r_pause;
    logic             r_help;
    logic [VEL_W-1:0] r_vel;

    ps2_prefix_fsm u_fsm (
        .clk           (clk),
        .reset         (reset),
        .i_code        (code),
        .i_code_valid  (code_valid),
        .i_timeout     (w_timeout),
        .o_make_valid  (w_make_valid),
        .o_break_valid (w_break_valid),
        .o_key_code    (w_key_code),
        .o_frame_err   (frame_err),
        .o_busy        (w_busy)
    );

    assign w_timeout = w_busy && !code_valid && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_hit[K_JUMP]  = (w_key_code == KEY_JUMP);
    assign w_hit[K_UP]    = (w_key_code == KEY_UP);
    assign w_hit[K_DN]    = (w_key_code == KEY_DN);
    assign w_hit[K_PAUSE] = (w_key_code == KEY_PAUSE);
    assign w_hit[K_HELP]  = (w_key_code == KEY_HELP);

    always_ff @(posedge clk) begin
        if (reset || !w_busy || code_valid || w_timeout) r_cnt <= '0;
        else                                             r_cnt <= r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_held   <= '0;
            r_press  <= '0;
            r_jump   <= 1'b0;
            r_pause  <= 1'b0;
            r_help   <= 1'b0;
            r_vel    <= VEL_W'(VEL_INIT);
        end else begin
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            // Repeat makes of an already-held key set held again but never pulse.
            r_press  <= (w_make_valid ? w_hit : 5'b0) & ~r_held;
            if (w_make_valid)       r_held <= r_held | w_hit;
            else if (w_break_valid) r_held <= r_held & ~w_hit;
            r_jump   <= r_held[K_JUMP] | r_btn_s2;
            r_pause  <= r_pause ^ r_press[K_PAUSE];
            r_help   <= r_help ^ r_press[K_HELP];
            if (!r_pause) begin
                if (r_press[K_UP] && !r_press[K_DN] && r_vel < VEL_W'(VEL_MAX))
                    r_vel <= r_vel + VEL_W'(1);
                else if (r_press[K_DN] && !r_press[K_UP] && r_vel > VEL_W'(VEL_MIN))
                    r_vel <= r_vel - VEL_W'(1);
            end
        end
    end

    assign jump     = r_jump;
    assign pause    = r_pause;
    assign help     = r_help;
    assign velocity = r_vel;
    assign held     = r_held;
    assign press    = r_press;

endmodule
